simd_exe_sequencer: RTL and testbench

// - Upstream feeder for the functional_unit array in the SIMD execute stage.
// - Accepts one VLEN-wide vector instruction with both source operands.
// - Slices the operands into 64-bit chunks and issues them to N_FU functional units,
//   one pass per cycle, driving a chunk-global fu_id so that VID numbers elements correctly.
// - Collects each pass's 64-bit results into the VLEN-wide destination and hands it on with valid/ready.

---
 rtl/simd_exe_sequencer.sv | 139 +++++++++++++
 tb/tb_simd_exe_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_exe_sequencer.sv
// Execute-stage sequencer: slices one VLEN-wide vector instruction into NPASS passes of N_FU
// 64-bit chunks, drives the functional-unit row, and reassembles the per-chunk results.
package simd_pkg;
  typedef enum logic [2:0] {VADD, VSUB, VAND, VOR, VXOR, VMV, VID} instr_type_t;
  typedef enum logic [1:0] {SEW_8, SEW_16, SEW_32, SEW_64} sew_t;
endpackage

module simd_exe_sequencer
  import simd_pkg::*;
#(
  parameter int unsigned VLEN    = 128,
  parameter int unsigned N_FU    = 1,
  parameter int unsigned FU_ID_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      kill_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  instr_type_t               instr_type_i,
  input  sew_t                      sew_i,
  input  logic [VLEN-1:0]           data_vs1_i,
  input  logic [VLEN-1:0]           data_vs2_i,
  output instr_type_t               fu_instr_type_o,
  output sew_t                      fu_sew_o,
  output logic [N_FU*64-1:0]        fu_vs1_o,
  output logic [N_FU*64-1:0]        fu_vs2_o,
  output logic [N_FU*FU_ID_W-1:0]   fu_id_o,
  input  logic [N_FU*64-1:0]        fu_vd_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [VLEN-1:0]           data_vd_o
);

  localparam int unsigned NPASS  = VLEN / (N_FU * 64);
  localparam int unsigned PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NPASS - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q;
  logic [PASS_W-1:0] pass_q;
  instr_type_t       type_q;
  sew_t              sew_q;
  logic [VLEN-1:0]   vs1_q;
  logic [VLEN-1:0]   vs2_q;
  logic [VLEN-1:0]   vd_q;
  logic              instr_ready_q;
  logic              result_valid_q;
  int unsigned       chunk_base;

  // Lane k of the current pass works on chunk chunk_base + k; fu_id is that global index.
  assign chunk_base = 32'(pass_q) * N_FU;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= StIdle;
      pass_q         <= '0;
      type_q         <= VADD;
      sew_q          <= SEW_8;
      vs1_q          <= '0;
      vs2_q          <= '0;
      vd_q           <= '0;
      instr_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else if (kill_i) begin
      state_q        <= StIdle;
      pass_q         <= '0;
      instr_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid_i && instr_ready_q) begin
            type_q        <= instr_type_i;
            sew_q         <= sew_i;
            vs1_q         <= data_vs1_i;
            vs2_q         <= data_vs2_i;
            pass_q        <= '0;
            instr_ready_q <= 1'b0;
            state_q       <= StExec;
          end
        end
        StExec: begin
          for (int unsigned k = 0; k < N_FU; k++) begin
            vd_q[(chunk_base + k)*64 +: 64] <= fu_vd_i[k*64 +: 64];
          end
          if (pass_q == LAST_PASS) begin
            state_q        <= StDone;
            result_valid_q <= 1'b1;
          end else begin
            pass_q <= pass_q + 1'b1;
          end
        end
        StDone: begin
          if (result_ready_i) begin
            state_q        <= StIdle;
            result_valid_q <= 1'b0;
            instr_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q        <= StIdle;
          instr_ready_q  <= 1'b1;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // FU-facing signals are quiet outside EXEC so idle FUs see a constant zero operand.
  always_comb begin
    fu_instr_type_o = VADD;
    fu_sew_o        = SEW_8;
    fu_vs1_o        = '0;
    fu_vs2_o        = '0;
    fu_id_o         = '0;
    if (state_q == StExec) begin
      fu_instr_type_o = type_q;
      fu_sew_o        = sew_q;
      for (int unsigned k = 0; k < N_FU; k++) begin
        fu_vs1_o[k*64 +: 64]           = vs1_q[(chunk_base + k)*64 +: 64];
        fu_vs2_o[k*64 +: 64]           = vs2_q[(chunk_base + k)*64 +: 64];
        fu_id_o[k*FU_ID_W +: FU_ID_W]  = FU_ID_W'(chunk_base + k);
      end
    end
  end

  assign instr_ready_o  = instr_ready_q;
  assign result_valid_o = result_valid_q;
  assign data_vd_o      = vd_q;

  a_ready_valid_excl : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(instr_ready_o && result_valid_o));

  a_result_held : assert property (@(posedge clk_i) disable iff (!rstn_i)
    result_valid_o && !result_ready_i && !kill_i |=> result_valid_o && $stable(data_vd_o));

endmodule

// File: tb/tb_simd_exe_sequencer.sv
// Bench for simd_exe_sequencer: three configurations (NPASS 2, 4, 1) share one stimulus stream,
// each checked every cycle against a timeline/whole-vector model plus literal spot checks.
module tb_simd_exe_sequencer;
  import simd_pkg::*;

  logic              clk;
  logic              rstn;
  logic              kill;
  logic              instr_valid;
  logic              result_ready;
  instr_type_t       instr_type;
  sew_t              sew;
  logic [255:0]      vs1;
  logic [255:0]      vs2;
  logic [2:0]        ready_all;
  logic [2:0]        valid_all;
  logic [2:0][255:0] vd_all;
  logic [2:0][15:0]  fid_all;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sew_mask(sew_t s);
    return (s == SEW_64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << int'(s))) - 64'd1);
  endfunction

  function automatic logic [63:0] elem_op(instr_type_t t, logic [63:0] x, logic [63:0] y,
                                          logic [63:0] idx);
    case (t)
      VADD:    return x + y;
      VSUB:    return x - y;
      VAND:    return x & y;
      VOR:     return x | y;
      VXOR:    return x ^ y;
      VMV:     return x;
      VID:     return idx;
      default: return 64'd0;
    endcase
  endfunction

  // Functional unit: one 64-bit chunk, element indices derived from the chunk-global fu_id.
  function automatic logic [63:0] fu_model(instr_type_t t, sew_t s, logic [63:0] a,
                                           logic [63:0] b, logic [7:0] id);
    int          esz;
    logic [63:0] m;
    logic [63:0] r;
    logic [63:0] e;
    esz = 8 << int'(s);
    m   = sew_mask(s);
    r   = '0;
    for (int j = 0; j < 64 / esz; j++) begin
      e = elem_op(t, (a >> (j*esz)) & m, (b >> (j*esz)) & m, 64'(id) * 64'(64 / esz) + 64'(j));
      r = r | ((e & m) << (j*esz));
    end
    return r;
  endfunction

  // Whole-vector reference: element i of the full register, no notion of chunks or passes.
  function automatic logic [255:0] ref_vector(instr_type_t t, sew_t s, logic [255:0] a,
                                              logic [255:0] b, int vl);
    int           esz;
    logic [63:0]  m;
    logic [63:0]  e;
    logic [255:0] r;
    esz = 8 << int'(s);
    m   = sew_mask(s);
    r   = '0;
    for (int i = 0; i < vl / esz; i++) begin
      e = elem_op(t, 64'(a >> (i*esz)) & m, 64'(b >> (i*esz)) & m, 64'(i));
      r = r | (256'(e & m) << (i*esz));
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int VL = (g == 2) ? 128 : 256;
    localparam int NF = (g == 1) ? 1 : 2;
    localparam int NP = VL / (NF * 64);

    logic             ready;
    logic             valid;
    instr_type_t      fu_type;
    sew_t             fu_sew;
    logic [NF*64-1:0] fvs1;
    logic [NF*64-1:0] fvs2;
    logic [NF*64-1:0] fvd;
    logic [NF*8-1:0]  fid;
    logic [VL-1:0]    vd;

    simd_exe_sequencer #(.VLEN(VL), .N_FU(NF), .FU_ID_W(8)) dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .kill_i          (kill),
      .instr_valid_i   (instr_valid),
      .instr_ready_o   (ready),
      .instr_type_i    (instr_type),
      .sew_i           (sew),
      .data_vs1_i      (vs1[VL-1:0]),
      .data_vs2_i      (vs2[VL-1:0]),
      .fu_instr_type_o (fu_type),
      .fu_sew_o        (fu_sew),
      .fu_vs1_o        (fvs1),
      .fu_vs2_o        (fvs2),
      .fu_id_o         (fid),
      .fu_vd_i         (fvd),
      .result_valid_o  (valid),
      .result_ready_i  (result_ready),
      .data_vd_o       (vd)
    );

    always_comb begin
      fvd = '0;
      for (int k = 0; k < NF; k++) begin
        fvd[k*64 +: 64] = fu_model(fu_type, fu_sew, fvs1[k*64 +: 64], fvs2[k*64 +: 64],
                                   fid[k*8 +: 8]);
      end
    end

    assign ready_all[g] = ready;
    assign valid_all[g] = valid;
    assign vd_all[g]    = 256'(vd);
    assign fid_all[g]   = 16'(fid);

    // Timeline model: an accepted instruction spends NP cycles issuing, then waits for ready.
    bit           m_act = 1'b0;
    int           m_t0 = 0;
    instr_type_t  m_type = VADD;
    sew_t         m_sew = SEW_8;
    logic [255:0] m_a = '0;
    logic [255:0] m_b = '0;
    logic [255:0] m_exp = '0;

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        m_act <= 1'b0;
      end else if (kill) begin
        m_act <= 1'b0;
      end else if (!m_act) begin
        if (instr_valid) begin
          m_act  <= 1'b1;
          m_t0   <= cyc + 1;
          m_type <= instr_type;
          m_sew  <= sew;
          m_a    <= vs1;
          m_b    <= vs2;
          m_exp  <= ref_vector(instr_type, sew, vs1, vs2, VL);
        end
      end else if ((cyc - m_t0 >= NP) && result_ready) begin
        m_act <= 1'b0;
      end
    end

    always @(posedge clk) begin
      int               s;
      bit               in_exec;
      logic [NF*64-1:0] e1;
      logic [NF*64-1:0] e2;
      logic [NF*8-1:0]  eid;
      logic [4:0]       ectl;
      #2;
      s       = cyc - m_t0;
      in_exec = m_act && (s < NP);
      e1 = '0;
      e2 = '0;
      eid = '0;
      ectl = '0;
      if (in_exec) begin
        ectl = {m_type, m_sew};
        for (int k = 0; k < NF; k++) begin
          e1[k*64 +: 64] = m_a[(s*NF + k)*64 +: 64];
          e2[k*64 +: 64] = m_b[(s*NF + k)*64 +: 64];
          eid[k*8 +: 8]  = 8'(s*NF + k);
        end
      end
      chk($sformatf("g%0d instr_ready", g), 256'(ready), 256'(!m_act));
      chk($sformatf("g%0d result_valid", g), 256'(valid), 256'(m_act && (s >= NP)));
      if (m_act && (s >= NP)) chk($sformatf("g%0d data_vd", g), 256'(vd), 256'(m_exp[VL-1:0]));
      chk($sformatf("g%0d fu_vs1", g), 256'(fvs1), 256'(e1));
      chk($sformatf("g%0d fu_vs2", g), 256'(fvs2), 256'(e2));
      chk($sformatf("g%0d fu_id", g), 256'(fid), 256'(eid));
      chk($sformatf("g%0d fu_type_sew", g), 256'({fu_type, fu_sew}), 256'(ectl));
    end
  end

  task automatic issue(input instr_type_t t, input sew_t s, input logic [255:0] a,
                       input logic [255:0] b);
    instr_valid = 1'b1;
    instr_type  = t;
    sew         = s;
    vs1         = a;
    vs2         = b;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ready_all != 3'b111 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("wait idle", 256'(ready_all), 256'd7);
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] e;
    logic [255:0] held;
    int           n;
    rstn = 1'b0;
    kill = 1'b0;
    instr_valid = 1'b0;
    result_ready = 1'b1;
    instr_type = VADD;
    sew = SEW_8;
    vs1 = '0;
    vs2 = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", 256'(ready_all), 256'd7);
    chk("reset valid", 256'(valid_all), 256'd0);
    chk("reset vd g0", vd_all[0], 256'd0);
    chk("reset fu_id", 256'({fid_all[0], fid_all[1], fid_all[2]}), 256'd0);
    rstn = 1'b1;
    @(negedge clk);

    // VADD SEW_64: 1 + 2 in every lane.
    a = {4{64'd1}};
    b = {4{64'd2}};
    e = {4{64'd3}};
    issue(VADD, SEW_64, a, b);
    @(negedge clk);
    chk("vadd g0 valid early", 256'(valid_all[0]), 256'd0);
    @(negedge clk);
    chk("vadd g0 valid", 256'(valid_all[0]), 256'd1);
    chk("vadd g0 vd", vd_all[0], e);
    wait_idle();
    chk("vadd g1 vd", vd_all[1], e);
    chk("vadd g2 vd", vd_all[2], 256'(e[127:0]));

    // VID SEW_8: byte i of the result equals i.
    a = {8{$urandom()}};
    b = {8{$urandom()}};
    e = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    issue(VID, SEW_8, a, b);
    chk("vid g0 fu_id pass0", 256'(fid_all[0]), 256'h0100);
    @(negedge clk);
    chk("vid g0 fu_id pass1", 256'(fid_all[0]), 256'h0302);
    wait_idle();
    chk("vid g0 vd", vd_all[0], e);
    chk("vid g1 vd", vd_all[1], e);
    chk("vid g2 vd", vd_all[2], 256'(e[127:0]));

    // VXOR with downstream stalled: result must hold.
    a = {4{64'hFF00_FF00_1234_5678}};
    b = {4{64'h0F0F_0F0F_FFFF_0000}};
    e = {4{64'hF00F_F00F_EDCB_5678}};
    result_ready = 1'b0;
    issue(VXOR, SEW_32, a, b);
    n = 0;
    while (valid_all != 3'b111 && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = vd_all[0];
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", 256'(valid_all), 256'd7);
      chk("stall ready", 256'(ready_all), 256'd0);
      chk("stall g0 vd", vd_all[0], e);
      chk("stall g0 vd stable", vd_all[0], held);
      chk("stall g2 vd", vd_all[2], 256'(e[127:0]));
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("after ready idle", 256'(ready_all), 256'd7);
    chk("after ready valid", 256'(valid_all), 256'd0);

    // Kill during pass 2 of the 4-pass configuration.
    issue(VADD, SEW_64, {4{64'h55}}, {4{64'h11}});
    @(negedge clk);
    @(negedge clk);
    chk("kill g1 fu_id pass2", 256'(fid_all[1]), 256'd2);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill ready", 256'(ready_all), 256'd7);
    chk("kill valid", 256'(valid_all), 256'd0);

    // Kill coinciding with an offered instruction: nothing accepted.
    instr_valid = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    kill = 1'b0;
    chk("kill+handshake ready", 256'(ready_all), 256'd7);
    @(negedge clk);
    chk("kill+handshake no valid", 256'(valid_all), 256'd0);

    // Follow-up VADD SEW_16 with per-element wraparound.
    a = {16{16'h8001}};
    b = {16{16'h8002}};
    e = {16{16'h0003}};
    issue(VADD, SEW_16, a, b);
    wait_idle();
    chk("post-kill g1 vd", vd_all[1], e);
    chk("post-kill g0 vd", vd_all[0], e);
    chk("post-kill g2 vd", vd_all[2], 256'(e[127:0]));

    // Asynchronous reset mid-EXEC.
    issue(VMV, SEW_64, {8{32'hDEAD_BEEF}}, '0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async rst ready", 256'(ready_all), 256'd7);
    chk("async rst valid", 256'(valid_all), 256'd0);
    chk("async rst vd g0", vd_all[0], 256'd0);
    chk("async rst vd g1", vd_all[1], 256'd0);
    chk("async rst fu_id", 256'({fid_all[0], fid_all[1], fid_all[2]}), 256'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post rst ready", 256'(ready_all), 256'd7);

    // VMV: NPASS=1 config returns vs1 two cycles after accept.
    a = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444,
         64'hAAAA_BBBB_CCCC_DDDD};
    b = {8{$urandom()}};
    issue(VMV, SEW_64, a, b);
    chk("vmv g2 exec no valid", 256'(valid_all[2]), 256'd0);
    chk("vmv g2 fu_id", 256'(fid_all[2]), 256'h0100);
    @(negedge clk);
    chk("vmv g2 valid", 256'(valid_all[2]), 256'd1);
    chk("vmv g2 vd", vd_all[2], 256'(a[127:0]));
    wait_idle();
    chk("vmv g0 vd", vd_all[0], a);
    chk("vmv g1 vd", vd_all[1], a);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
